// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: FSM encoding and ROM word layout.
package song_reader_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_ROMWAIT = 3'd2;
  localparam logic [2:0] ST_LOAD    = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_PLAYING = 3'd5;
  localparam logic [2:0] ST_END     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_ROMWAIT = ST_ROMWAIT,
    S_LOAD    = ST_LOAD,
    S_SETTLE  = ST_SETTLE,
    S_PLAYING = ST_PLAYING,
    S_END     = ST_END
  } state_t;

  // ROM word is {note, duration}; duration sits in the low bits.
  localparam int DUR_LSB    = 0;
  localparam int END_MARKER = 0;

endpackage

// File: rtl/song_reader.sv
// Song sequencer: walks {note, duration} entries of one song in an external ROM
// and hands each to note_player with a single-cycle load pulse.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int SONG_BITS  = 2,
  parameter int INDEX_BITS = 5,
  parameter int NOTE_BITS  = 6,
  parameter int DUR_BITS   = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic                            new_song,
  input  logic [SONG_BITS-1:0]            song_sel,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0]   rom_data,
  output logic [NOTE_BITS-1:0]            note_to_load,
  output logic [DUR_BITS-1:0]             duration_to_load,
  output logic                            load_new_note,
  input  logic                            done_with_note,
  output logic                            play_enable,
  output logic                            song_done,
  output logic                            busy
);

  localparam int DUR_MSB  = DUR_LSB + DUR_BITS - 1;
  localparam int NOTE_LSB = DUR_LSB + DUR_BITS;
  localparam int NOTE_MSB = NOTE_LSB + NOTE_BITS - 1;
  localparam logic [INDEX_BITS-1:0] INDEX_MAX = '1;

  state_t                  state;
  logic [SONG_BITS-1:0]    cur_song;
  logic [INDEX_BITS-1:0]   note_index;
  logic [NOTE_BITS-1:0]    rom_note;
  logic [DUR_BITS-1:0]     rom_dur;

  assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      cur_song         <= '0;
      note_index       <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
    end else if (new_song) begin
      // A restart overrides pause and any in-flight note.
      cur_song   <= song_sel;
      note_index <= '0;
      state      <= S_FETCH;
    end else begin
      case (state)
        S_IDLE:    state <= S_IDLE;
        S_FETCH:   if (play) state <= S_ROMWAIT;
        S_ROMWAIT: if (play) begin
          if (rom_dur == DUR_BITS'(END_MARKER)) begin
            state <= S_END;
          end else begin
            note_to_load     <= rom_note;
            duration_to_load <= rom_dur;
            state            <= S_LOAD;
          end
        end
        S_LOAD:    if (play) state <= S_SETTLE;
        // SETTLE exists so the previous note's stale done level is never seen.
        S_SETTLE:  if (play) state <= S_PLAYING;
        S_PLAYING: if (play && done_with_note) begin
          if (note_index == INDEX_MAX) begin
            state <= S_END;
          end else begin
            note_index <= note_index + INDEX_BITS'(1);
            state      <= S_FETCH;
          end
        end
        S_END:     state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Pulses are gated so a paused LOAD defers its pulse and a restart suppresses both.
  assign busy          = (state != S_IDLE);
  assign play_enable   = play & busy;
  assign load_new_note = (state == S_LOAD) & play & ~new_song;
  assign song_done     = (state == S_END) & ~new_song;
  assign rom_addr      = {cur_song, note_index};

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: cycle table for a short song plus sequences for pause,
// abort, a full 32-entry song and mid-song reset; loads checked via a scoreboard.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset, play, new_song, done_with_note;
  logic [1:0]  song_sel;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load, duration_to_load;
  logic        load_new_note, play_enable, song_done, busy;

  logic [11:0] rom [0:127];
  logic [11:0] exp_q [$];
  logic [11:0] exp_e;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          sd_count = 0;
  int          sd_before;

  typedef struct {
    logic       ns;
    logic [1:0] sel;
    logic       play;
    logic       done;
    logic       load;
    logic       sd;
    logic       busy;
    logic       pe;
    logic [6:0] addr;
  } vec_t;
  vec_t vecs [17];

  song_reader #(.SONG_BITS(2), .INDEX_BITS(5), .NOTE_BITS(6), .DUR_BITS(6)) dut (
    .clk(clk), .reset(reset), .play(play), .new_song(new_song), .song_sel(song_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .done_with_note(done_with_note), .play_enable(play_enable),
    .song_done(song_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every load pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && load_new_note) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL load_unexpected: got note 0x%0h dur 0x%0h, expected no load at %0t",
                 note_to_load, duration_to_load, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("load_note", 32'(note_to_load), 32'(exp_e[11:6]));
        check("load_dur", 32'(duration_to_load), 32'(exp_e[5:0]));
      end
    end
    if (!reset && song_done) sd_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      found = load_new_note;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: got no load_new_note in 12 cycles, expected a pulse", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0]  = {6'd10, 6'd4};
    rom[1]  = {6'd12, 6'd2};
    rom[32] = {6'd20, 6'd5};
    rom[33] = {6'd21, 6'd6};
    rom[64] = {6'd30, 6'd7};
    rom[65] = {6'd31, 6'd1};
    for (int i = 0; i < 32; i++) rom[96+i] = {6'(i + 33), 6'(i + 1)};

    //           ns    sel   play  done  load  sd    busy  pe    addr
    vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'd1};
    vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd1};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd2};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd2};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'd2};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2};

    reset = 1'b1; play = 1'b0; new_song = 1'b0; done_with_note = 1'b0; song_sel = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load_new_note), 32'd0);
    check("rst_done", 32'(song_done), 32'd0);
    check("rst_pe", 32'(play_enable), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_note", 32'({note_to_load, duration_to_load}), 32'd0);

    // Song 0: two notes then end marker, stale done held through LOAD/SETTLE.
    exp_q.push_back({6'd10, 6'd4});
    exp_q.push_back({6'd12, 6'd2});
    for (int i = 0; i < 17; i++) begin
      tick();
      new_song = vecs[i].ns; song_sel = vecs[i].sel;
      play = vecs[i].play; done_with_note = vecs[i].done;
      @(negedge clk);
      check($sformatf("v%0d_load", i), 32'(load_new_note), 32'(vecs[i].load));
      check($sformatf("v%0d_sdone", i), 32'(song_done), 32'(vecs[i].sd));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_pe", i), 32'(play_enable), 32'(vecs[i].pe));
      check($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
    end

    // Pause in ROMWAIT for 5 cycles.
    exp_q.push_back({6'd20, 6'd5});
    tick(); new_song = 1'b1; song_sel = 2'd1; play = 1'b1; done_with_note = 1'b0;
    tick(); new_song = 1'b0;
    tick(); play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("pause%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("pause%0d_pe", i), 32'(play_enable), 32'd0);
      check($sformatf("pause%0d_load", i), 32'(load_new_note), 32'd0);
      check($sformatf("pause%0d_addr", i), 32'(rom_addr), 32'd32);
      tick();
    end
    play = 1'b1;
    @(negedge clk);
    check("resume_pe", 32'(play_enable), 32'd1);
    check("resume_load_early", 32'(load_new_note), 32'd0);
    tick();
    @(negedge clk);
    check("resume_load", 32'(load_new_note), 32'd1);

    // Abort mid-note with new_song and done in the same cycle.
    tick();
    tick(); new_song = 1'b1; song_sel = 2'd2; done_with_note = 1'b1;
    exp_q.push_back({6'd30, 6'd7});
    sd_before = sd_count;
    tick(); new_song = 1'b0; done_with_note = 1'b0;
    @(negedge clk);
    check("abort_addr", 32'(rom_addr), 32'b10_00000);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_load", 32'(load_new_note), 32'd0);
    wait_load("abort_first_load");
    check("abort_no_sdone", 32'(sd_count), 32'(sd_before));

    // Full 32-entry song; last index must end without wrapping.
    tick(); new_song = 1'b1; song_sel = 2'd3;
    for (int i = 0; i < 32; i++) exp_q.push_back(rom[96+i]);
    sd_before = sd_count;
    tick(); new_song = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wait_load($sformatf("full_load%0d", i));
      tick(); done_with_note = 1'b1;
      tick();
      tick(); done_with_note = 1'b0;
    end
    @(negedge clk);
    check("full_sdone", 32'(song_done), 32'd1);
    check("full_addr_end", 32'(rom_addr), 32'd127);
    check("full_busy_end", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("full_busy_idle", 32'(busy), 32'd0);
    check("full_sdone_clr", 32'(song_done), 32'd0);
    check("full_addr_idle", 32'(rom_addr), 32'd127);
    check("full_sdone_count", 32'(sd_count), 32'(sd_before + 1));

    // Reset while PLAYING.
    tick(); new_song = 1'b1; song_sel = 2'd3;
    exp_q.push_back(rom[96]);
    tick(); new_song = 1'b0;
    wait_load("rst_song_load");
    tick();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_pe", 32'(play_enable), 32'd0);
    check("mrst_addr", 32'(rom_addr), 32'd0);
    check("mrst_note", 32'(note_to_load), 32'd0);
    check("mrst_dur", 32'(duration_to_load), 32'd0);
    check("mrst_load", 32'(load_new_note), 32'd0);
    check("mrst_sdone", 32'(song_done), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("sdone_total", 32'(sd_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
